b10_down_timer: RTL and testbench
=================================

Name: b10_down_timer

Overview:
- Multi-digit BCD down counter wrapped in a countdown-timer control FSM. This is the counterpart of the team's BCD up-counter digit: it decrements, and a borrow ripples up through the digits.
- Loads a BCD preset on start, counts down on each enabled clock, and flags expiry at zero. Optionally reloads the preset and keeps running.
- Sits next to the up-counter chain in the timing/clock-display datapath.

Parameters:
- DIGITS, 2, number of BCD digits; the count width is 4*DIGITS.
- RELOAD, 0, 1 = reload the preset on expiry and keep running; 0 = stop at expiry.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request: latch d and begin counting.
- abort  in  1  return to IDLE; count is held.
- ei  in  1  count enable (tick); one decrement per clock with ei=1 in RUN.
- d  in  4*DIGITS  BCD preset; digit i is d[4i+3:4i].
- q  out  4*DIGITS  current BCD count.
- running  out  1  high while the FSM is in RUN.
- done  out  1  one-cycle pulse on expiry.
- expired  out  1  level, high in DONE state (RELOAD=0 only).
- eu  out  1  borrow out: high combinationally when ei=1, the FSM is in RUN and q is all-zero.

Behaviour:
- Reset, asynchronous and immediate on the rising edge of reset: q=0, state=IDLE, running=0, done=0, expired=0. While reset is high, all inputs are ignored.
- States:
  - IDLE: waits for start.
  - RUN: counting.
  - DONE: terminal state when RELOAD=0.
- Load: in any state, start=1 at a clock edge does the following:
  - q <= sat(d), where each preset digit >9 is saturated to 9.
  - Next state is RUN, done=0.
  - Takes one cycle; the first decrement can happen on the following edge.
- Preset of zero: start with sat(d)=0 enters RUN with q=0. On the first ei edge, expiry fires (see Expiry).
- Decrement in RUN with ei=1:
  - Digit 0 always decrements.
  - Digit i>0 decrements only when ei=1 and digits 0..i-1 are all 0 (borrow ripple).
  - A digit at 0 that decrements wraps to 9.
  - Each digit stays within 0..9 at all times.
- ei=0 in RUN: q holds.
- ei in IDLE or DONE: ignored.
- Expiry, at an edge in RUN with ei=1 and q=0, where q reaches 0 by counting or by loading a zero preset:
  - done pulses high for exactly the following cycle.
  - RELOAD=0: q stays 0, next state is DONE, expired=1, running=0.
  - RELOAD=1: q <= sat(d) as sampled at that edge, state stays RUN, expired stays 0.
- Consequence of the expiry rule: the period from a preset of N is N+1 enabled ticks (N..0 inclusive), and done follows the tick at which q is already 0.
- abort=1 at an edge: next state is IDLE and q holds its value. abort has no effect in IDLE.
- start and abort at the same edge: start wins.
- start and expiry at the same edge: start wins and done is not pulsed.
- DONE to RUN only via start. abort takes DONE to IDLE and clears expired.
- Reset asserted mid-count aborts immediately. After reset is released, the block requires start.
- Outputs running, expired and done are registered. eu is combinational and is intended to chain to a more-significant timer's ei.

Test Plan:
1. Reset and load: reset pulse, then start with d=8'h25 and ei held at 1.
   - Required: q = 25, 24, … , 20, 19, … , 00.
   - done pulses on the edge after q=00 is seen with ei=1.
   - expired=1, q stays 00, running=0.
2. Borrow and wrap with DIGITS=3: d=12'h100, one ei tick.
   - Required: q=099; the next tick gives 098.
3. ei gating: d=8'h05, ei toggling 1,0,1,0.
   - Required: q decrements only on ei=1 edges (05, 04, 04, 03, 03).
   - ei=1 while in IDLE leaves q unchanged.
4. RELOAD=1: d=8'h02, ei=1 continuously.
   - Required: q=02, 01, 00, 02, 01, 00, …
   - done pulses once every 3 ticks; expired is never asserted.
5. Saturation and zero preset.
   - d=8'hAF loads q=99.
   - d=8'h00 gives done on the first ei tick.
6. Priority and reset:
   - start+abort at the same edge gives RUN with q=sat(d).
   - abort at q=13 gives IDLE with q=13.
   - reset asserted between clock edges clears q to 00 and running to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/b10_down_timer_if.sv
// Control and status bundle for the BCD countdown timer: start/abort/tick/preset in,
// count and status out. state carries the FSM encoding for observation.
interface b10_down_timer_if #(
  parameter int DIGITS = 2
);
  // start and abort are single-cycle level requests sampled at each rising clock edge;
  // there is no ready/ack, so a request held high is simply re-applied on every edge.
  logic                  start;
  logic                  abort;
  logic                  ei;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  expired;
  logic                  eu;
  logic [1:0]            state;

  modport master (
    output start, abort, ei, d,
    input  q, running, done, expired, eu, state
  );

  modport slave (
    input  start, abort, ei, d,
    output q, running, done, expired, eu, state
  );
endinterface

// File: rtl/b10_down_timer.sv
// Multi-digit BCD down counter under an IDLE/RUN/DONE timer FSM; a borrow ripples
// up through the digits and eu chains expiry into a more-significant timer.
module b10_down_timer #(
  parameter int DIGITS = 2,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  b10_down_timer_if.slave  bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic           expired_q, expired_d;
  logic [W-1:0]   preset;
  logic [W-1:0]   q_dec;
  logic           q_zero;
  logic           expire;

  assign q_zero = (q_q == '0);
  assign expire = (state_q == RUN) && bus.ei && q_zero;

  // Preset digits above 9 saturate so every stored digit stays a legal BCD value.
  always_comb begin
    preset = '0;
    for (int i = 0; i < DIGITS; i++) begin
      preset[4*i +: 4] = (bus.d[4*i +: 4] > 4'd9) ? 4'd9 : bus.d[4*i +: 4];
    end
  end

  always_comb begin
    logic borrow;
    q_dec  = q_q;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        q_dec[4*i +: 4] = (q_q[4*i +: 4] == 4'd0) ? 4'd9 : (q_q[4*i +: 4] - 4'd1);
      end
      borrow = borrow && (q_q[4*i +: 4] == 4'd0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  // start outranks abort, and abort outranks expiry.
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = RUN;
    end else if (bus.abort) begin
      state_d = IDLE;
    end else if (expire && !RELOAD) begin
      state_d = DONE;
    end
  end

  always_comb begin
    q_d    = q_q;
    done_d = 1'b0;
    if (bus.start) begin
      q_d = preset;
    end else if (bus.abort) begin
      q_d = q_q;
    end else if (expire) begin
      done_d = 1'b1;
      q_d    = RELOAD ? preset : q_q;
    end else if ((state_q == RUN) && bus.ei) begin
      q_d = q_dec;
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  assign bus.q       = q_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;
  assign bus.eu      = expire;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_b10_down_timer.sv
// Bench for b10_down_timer: three instances (2-digit stop, 3-digit stop, 2-digit reload)
// share the clock and stimulus; an integer model feeds an expected queue per edge.
module tb_b10_down_timer;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  // Integer model state per instance: 0 = 2-digit, 1 = 3-digit, 2 = 2-digit reload.
  int m_n[3];
  int m_st[3];
  int m_done[3];

  b10_down_timer_if #(.DIGITS(2)) if0 ();
  b10_down_timer_if #(.DIGITS(3)) if1 ();
  b10_down_timer_if #(.DIGITS(2)) if2 ();

  b10_down_timer #(.DIGITS(2), .RELOAD(1'b0)) u_d2 (.clock(clk), .reset(rst), .bus(if0));
  b10_down_timer #(.DIGITS(3), .RELOAD(1'b0)) u_d3 (.clock(clk), .reset(rst), .bus(if1));
  b10_down_timer #(.DIGITS(2), .RELOAD(1'b1)) u_rl (.clock(clk), .reset(rst), .bus(if2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ndig(input int sel);
    return (sel == 1) ? 3 : 2;
  endfunction

  function automatic int sat_val(input int sel, input logic [11:0] dv);
    int v;
    int dg;
    v = 0;
    for (int i = ndig(sel) - 1; i >= 0; i--) begin
      dg = int'(dv[4*i +: 4]);
      if (dg > 9) dg = 9;
      v = v * 10 + dg;
    end
    return v;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[3:0]  = 4'(n % 10);
    r[7:4]  = 4'((n / 10) % 10);
    r[11:8] = 4'((n / 100) % 10);
    return r;
  endfunction

  function automatic logic [15:0] model_pack(input int sel);
    return {1'b0, to_bcd(m_n[sel]), (m_st[sel] == 1), (m_done[sel] == 1), (m_st[sel] == 2)};
  endfunction

  function automatic logic [15:0] dut_pack(input int sel);
    case (sel)
      0:       return {5'b0, if0.q, if0.running, if0.done, if0.expired};
      1:       return {1'b0, if1.q, if1.running, if1.done, if1.expired};
      default: return {5'b0, if2.q, if2.running, if2.done, if2.expired};
    endcase
  endfunction

  function automatic logic dut_eu(input int sel);
    case (sel)
      0:       return if0.eu;
      1:       return if1.eu;
      default: return if2.eu;
    endcase
  endfunction

  // Model of one edge: state 0 = IDLE, 1 = RUN, 2 = DONE.
  task automatic model_step(input int sel, input logic s, input logic a, input logic e,
                            input logic [11:0] dv);
    int pre;
    pre = sat_val(sel, dv);
    m_done[sel] = 0;
    if (s) begin
      m_n[sel]  = pre;
      m_st[sel] = 1;
    end else if (a) begin
      m_st[sel] = 0;
    end else if (m_st[sel] == 1 && e) begin
      if (m_n[sel] == 0) begin
        m_done[sel] = 1;
        if (sel == 2) m_n[sel] = pre;
        else          m_st[sel] = 2;
      end else begin
        m_n[sel] = m_n[sel] - 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_st[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic e, input logic [11:0] dv);
    if0.start = s; if0.abort = a; if0.ei = e; if0.d = dv[7:0];
    if1.start = s; if1.abort = a; if1.ei = e; if1.d = dv;
    if2.start = s; if2.abort = a; if2.ei = e; if2.d = dv[7:0];
  endtask

  // One clock: drive, check eu before the edge, predict, then compare after the edge.
  task automatic cyc(input logic s, input logic a, input logic e, input logic [11:0] dv);
    logic [15:0] ex;
    drive(s, a, e, dv);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("eu%0d", k), {15'b0, dut_eu(k)},
          {15'b0, (e && m_st[k] == 1 && m_n[k] == 0)});
      model_step(k, s, a, e, dv);
      exp_q.push_back(model_pack(k));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      ex = exp_q.pop_front();
      chk($sformatf("out%0d", k), dut_pack(k), ex);
    end
  endtask

  task automatic ticks(input int n, input logic e, input logic [11:0] dv);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, e, dv);
  endtask

  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) chk($sformatf("async_rst%0d", k), dut_pack(k), model_pack(k));
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 12'h000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset%0d", k), dut_pack(k), model_pack(k));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load 25 and run through expiry into DONE.
    cyc(1'b1, 1'b0, 1'b1, 12'h025);
    ticks(28, 1'b1, 12'h025);

    // Borrow ripple across digits; 2-digit instances load 00 and expire.
    cyc(1'b1, 1'b0, 1'b0, 12'h100);
    ticks(3, 1'b1, 12'h100);

    // ei gating, then abort and ei while idle.
    cyc(1'b1, 1'b0, 1'b0, 12'h005);
    cyc(1'b0, 1'b0, 1'b1, 12'h005);
    cyc(1'b0, 1'b0, 1'b0, 12'h005);
    cyc(1'b0, 1'b0, 1'b1, 12'h005);
    cyc(1'b0, 1'b0, 1'b0, 12'h005);
    cyc(1'b0, 1'b1, 1'b0, 12'h005);
    ticks(2, 1'b1, 12'h005);

    // Preset 2 with continuous ticks: reload instance cycles 02,01,00.
    cyc(1'b1, 1'b0, 1'b1, 12'h002);
    ticks(10, 1'b1, 12'h002);

    // Saturation, then zero preset.
    cyc(1'b1, 1'b0, 1'b0, 12'h0AF);
    ticks(2, 1'b1, 12'h0AF);
    cyc(1'b1, 1'b0, 1'b0, 12'h000);
    ticks(3, 1'b1, 12'h000);

    // start+abort together; abort at 13; start beats a same-edge expiry.
    cyc(1'b1, 1'b1, 1'b0, 12'h015);
    ticks(2, 1'b1, 12'h015);
    cyc(1'b0, 1'b1, 1'b1, 12'h015);
    ticks(2, 1'b1, 12'h015);
    cyc(1'b1, 1'b0, 1'b0, 12'h001);
    ticks(1, 1'b1, 12'h001);
    cyc(1'b1, 1'b0, 1'b1, 12'h003);
    ticks(2, 1'b1, 12'h003);

    // Reset mid-count between edges, then ticks without start stay idle.
    cyc(1'b1, 1'b0, 1'b0, 12'h040);
    ticks(3, 1'b1, 12'h040);
    async_reset();
    ticks(3, 1'b1, 12'h040);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
